ex_stage: RTL

Execute stage of the 5-stage LoongArch pipeline. It sits between decode and memory stages.
- Accepts the 148-bit decode-to-execute bus under a valid/allowin handshake and registers it.
- Computes the ALU result and issues the data-SRAM request for loads and stores.
- Forwards {load-pending, we, waddr, result} back to decode for bypass and load-use stall.
- Passes a 71-bit bundle to the memory stage.

---
 rtl/ex_stage_pkg.sv | 76 +++++++
 rtl/ex_stage_alu.sv | 46 ++++
 rtl/ex_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: constants and bus layouts shared by the pipeline stages.
// Contents:
//   - ALU_OP_* one-hot bit indices for the 12-bit alu_op field.
//   - Bus widths ID2EX_W / EX2MEM_W / EXFWD_W and the field offsets of each bus.
//   - Packed structs whose member order matches the bus layouts, MSB first.
package ex_stage_pkg;

   localparam int ID2EX_W  = 148;
   localparam int EX2MEM_W = 71;
   localparam int EXFWD_W  = 39;

   localparam int ALU_OP_W    = 12;
   localparam int ALU_OP_ADD  = 0;
   localparam int ALU_OP_SUB  = 1;
   localparam int ALU_OP_SLT  = 2;
   localparam int ALU_OP_SLTU = 3;
   localparam int ALU_OP_AND  = 4;
   localparam int ALU_OP_NOR  = 5;
   localparam int ALU_OP_OR   = 6;
   localparam int ALU_OP_XOR  = 7;
   localparam int ALU_OP_SLL  = 8;
   localparam int ALU_OP_SRL  = 9;
   localparam int ALU_OP_SRA  = 10;
   localparam int ALU_OP_LUI  = 11;

   // decode -> execute field offsets
   localparam int ID_ALU_OP_LSB   = 136;
   localparam int ID_SRC1_LSB     = 104;
   localparam int ID_SRC2_LSB     = 72;
   localparam int ID_RF_WE        = 71;
   localparam int ID_WADDR_LSB    = 66;
   localparam int ID_PC_LSB       = 34;
   localparam int ID_MEM_WE       = 33;
   localparam int ID_RKD_LSB      = 1;
   localparam int ID_RES_FROM_MEM = 0;

   // execute -> memory field offsets
   localparam int EM_PC_LSB       = 39;
   localparam int EM_RES_FROM_MEM = 38;
   localparam int EM_RF_WE        = 37;
   localparam int EM_WADDR_LSB    = 32;
   localparam int EM_RESULT_LSB   = 0;

   // forwarding bundle field offsets
   localparam int FW_RES_FROM_MEM = 38;
   localparam int FW_RF_WE        = 37;
   localparam int FW_WADDR_LSB    = 32;

   typedef struct packed {
      logic [ALU_OP_W-1:0] alu_op;
      logic [31:0]         alu_src1;
      logic [31:0]         alu_src2;
      logic                rf_we;
      logic [4:0]          rf_waddr;
      logic [31:0]         pc;
      logic                mem_we;
      logic [31:0]         rkd_value;
      logic                res_from_mem;
   } id2ex_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        res_from_mem;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] alu_result;
   } ex2mem_t;

   typedef struct packed {
      logic        res_from_mem;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] alu_result;
   } exfwd_t;

endpackage

// File: rtl/ex_stage_alu.sv
// alu: purely combinational 32-bit ALU driven by a one-hot operation vector.
// Ports:
//   alu_op [11:0] in  one-hot operation select (ALU_OP_* indices)
//   src1   [31:0] in  first operand
//   src2   [31:0] in  second operand (shift amount is src2[4:0])
//   result [31:0] out operation result; zero when no op bit is set
module alu
   import ex_stage_pkg::*;
(
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic [31:0]         src1,
   input  logic [31:0]         src2,
   output logic [31:0]         result
);

   logic [31:0] add_res;
   logic [31:0] sub_res;
   logic        slt_res;
   logic        sltu_res;
   logic [31:0] sll_res;
   logic [31:0] srl_res;
   logic [31:0] sra_res;

   assign add_res  = src1 + src2;
   assign sub_res  = src1 - src2;
   assign slt_res  = $signed(src1) < $signed(src2);
   assign sltu_res = src1 < src2;
   assign sll_res  = src1 << src2[4:0];
   assign srl_res  = src1 >> src2[4:0];
   assign sra_res  = $unsigned($signed(src1) >>> src2[4:0]);

   // AND-OR mux: each op masks its own result, so an all-zero op yields 0.
   assign result = ({32{alu_op[ALU_OP_ADD]}}  & add_res)
                 | ({32{alu_op[ALU_OP_SUB]}}  & sub_res)
                 | ({32{alu_op[ALU_OP_SLT]}}  & {31'd0, slt_res})
                 | ({32{alu_op[ALU_OP_SLTU]}} & {31'd0, sltu_res})
                 | ({32{alu_op[ALU_OP_AND]}}  & (src1 & src2))
                 | ({32{alu_op[ALU_OP_NOR]}}  & ~(src1 | src2))
                 | ({32{alu_op[ALU_OP_OR]}}   & (src1 | src2))
                 | ({32{alu_op[ALU_OP_XOR]}}  & (src1 ^ src2))
                 | ({32{alu_op[ALU_OP_SLL]}}  & sll_res)
                 | ({32{alu_op[ALU_OP_SRL]}}  & srl_res)
                 | ({32{alu_op[ALU_OP_SRA]}}  & sra_res)
                 | ({32{alu_op[ALU_OP_LUI]}}  & src2);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
// Ports:
//   clk, resetn             clock and synchronous active-low reset
//   id_to_ex_valid/_wire    instruction from decode (148-bit bus)
//   ex_allowin              this stage can accept an instruction this cycle
//   mem_allowin             memory stage can accept
//   ex_to_mem_valid/_wire   instruction handed to memory (71-bit bus)
//   ex_rf_zip               {load-pending, we, waddr, result} for decode bypass/stall
//   data_sram_*             data SRAM request for loads and stores
//
// Handshake: a transfer between two stages happens on a rising edge where
// the producer's valid and the consumer's allowin are both 1. Valid may be
// raised regardless of allowin; the payload must stay stable while valid is
// high and allowin is low.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                id_to_ex_valid,
   input  logic [ID2EX_W-1:0]  id_to_ex_wire,
   output logic                ex_allowin,
   input  logic                mem_allowin,
   output logic                ex_to_mem_valid,
   output logic [EX2MEM_W-1:0] ex_to_mem_wire,
   output logic [EXFWD_W-1:0]  ex_rf_zip,
   output logic                data_sram_en,
   output logic [3:0]          data_sram_we,
   output logic [31:0]         data_sram_addr,
   output logic [31:0]         data_sram_wdata
);

   logic        ex_valid;
   id2ex_t      ex_payload;
   logic        ex_ready_go;
   logic [31:0] alu_result;
   ex2mem_t     to_mem;
   exfwd_t      fwd;

   // every operation completes in one cycle
   assign ex_ready_go     = 1'b1;
   assign ex_allowin      = ~ex_valid | (ex_ready_go & mem_allowin);
   assign ex_to_mem_valid = ex_valid & ex_ready_go;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ex_valid   <= 1'b0;
         ex_payload <= '0;
      end else begin
         if (ex_allowin) begin
            ex_valid <= id_to_ex_valid;
         end
         // payload only moves on an accept, so a stall holds it stable
         if (id_to_ex_valid && ex_allowin) begin
            ex_payload <= id2ex_t'(id_to_ex_wire);
         end
      end
   end

   alu u_alu (
      .alu_op (ex_payload.alu_op),
      .src1   (ex_payload.alu_src1),
      .src2   (ex_payload.alu_src2),
      .result (alu_result)
   );

   // Request only on hand-off so a stalled store issues exactly once.
   assign data_sram_en    = ex_valid & mem_allowin & (ex_payload.mem_we | ex_payload.res_from_mem);
   assign data_sram_we    = {4{ex_payload.mem_we & ex_valid & mem_allowin}};
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = ex_payload.rkd_value;

   always_comb begin
      to_mem              = '0;
      to_mem.pc           = ex_payload.pc;
      to_mem.res_from_mem = ex_payload.res_from_mem;
      to_mem.rf_we        = ex_payload.rf_we;
      to_mem.rf_waddr     = ex_payload.rf_waddr;
      to_mem.alu_result   = alu_result;
   end
   assign ex_to_mem_wire = to_mem;

   // enable bits are qualified with ex_valid so an empty stage never forwards
   always_comb begin
      fwd              = '0;
      fwd.res_from_mem = ex_payload.res_from_mem & ex_valid;
      fwd.rf_we        = ex_payload.rf_we & ex_valid;
      fwd.rf_waddr     = ex_payload.rf_waddr;
      fwd.alu_result   = alu_result;
   end
   assign ex_rf_zip = fwd;

endmodule
